tmr_scrub_bank: RTL and testbench

- Triplicated register bank: every word is held as three copies (A/B/C); reads return the per-bit majority vote.
- Background scrubber walks the bank, detects copy disagreement and rewrites all three copies with the voted value.
- Consumer side of the TMR storage cells in the rad-hard library; it is the voter/corrector that the triplicated set/reset flops require.
- Sits between a register-file client and the triplicated storage; includes a fault-injection port for SEU emulation in verification.

---
 rtl/tmr_scrub_bank.sv | 180 ++++++++++++++++++
 tb/tb_tmr_scrub_bank.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_scrub_bank.sv
// Triplicated register bank with majority-vote reads and a background scrubber
// that rewrites disagreeing words with their voted value.
module tmr_scrub_bank #(
    parameter int unsigned      WIDTH     = 8,
    parameter int unsigned      DEPTH     = 16,
    parameter int unsigned      AW        = $clog2(DEPTH),
    parameter int unsigned      SCRUB_GAP = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             WE,
    input  logic [AW-1:0]    WADDR,
    input  logic [WIDTH-1:0] WDATA,
    input  logic             RE,
    input  logic [AW-1:0]    RADDR,
    output logic [WIDTH-1:0] RDATA,
    output logic             RVALID,
    output logic             RCORR,
    input  logic             SCRUB_EN,
    output logic             SCRUB_BUSY,
    output logic             SCRUB_DONE,
    output logic [15:0]      ERR_CNT,
    input  logic             CLR_CNT,
    input  logic             FI_EN,
    input  logic [1:0]       FI_COPY,
    input  logic [AW-1:0]    FI_ADDR,
    input  logic [WIDTH-1:0] FI_MASK
);

    localparam int unsigned GW = (SCRUB_GAP > 1) ? $clog2(SCRUB_GAP) : 1;

    typedef enum logic [1:0] {StIdle, StCheck, StGap} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             done_q, done_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             rcorr_q, rcorr_d;

    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [WIDTH-1:0] mem_c_q [DEPTH];

    logic [WIDTH-1:0] rd_vote, sc_vote;
    logic             rd_mis, sc_mis;
    logic             scrub_hit;

    function automatic logic [WIDTH-1:0] vote3(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    assign rd_vote = vote3(mem_a_q[RADDR], mem_b_q[RADDR], mem_c_q[RADDR]);
    assign rd_mis  = (mem_a_q[RADDR] != mem_b_q[RADDR]) || (mem_b_q[RADDR] != mem_c_q[RADDR]);
    assign sc_vote = vote3(mem_a_q[ptr_q], mem_b_q[ptr_q], mem_c_q[ptr_q]);
    assign sc_mis  = (mem_a_q[ptr_q] != mem_b_q[ptr_q]) || (mem_b_q[ptr_q] != mem_c_q[ptr_q]);

    // Per-word priority: client write, then scrub repair, then fault injection.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_a_q[i] <= RESET_VAL;
                mem_b_q[i] <= RESET_VAL;
                mem_c_q[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (WE && (WADDR == AW'(i))) begin
                    mem_a_q[i] <= WDATA;
                    mem_b_q[i] <= WDATA;
                    mem_c_q[i] <= WDATA;
                end else if (scrub_hit && (ptr_q == AW'(i))) begin
                    mem_a_q[i] <= sc_vote;
                    mem_b_q[i] <= sc_vote;
                    mem_c_q[i] <= sc_vote;
                end else if (FI_EN && (FI_ADDR == AW'(i))) begin
                    if (FI_COPY == 2'd0) mem_a_q[i] <= mem_a_q[i] ^ FI_MASK;
                    if (FI_COPY == 2'd1) mem_b_q[i] <= mem_b_q[i] ^ FI_MASK;
                    if (FI_COPY == 2'd2) mem_c_q[i] <= mem_c_q[i] ^ FI_MASK;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        scrub_hit = 1'b0;
        unique case (state_q)
            StIdle: begin
                ptr_d = '0;
                if (SCRUB_EN) state_d = StCheck;
            end
            StCheck: begin
                scrub_hit = sc_mis;
                gap_d     = '0;
                if (ptr_q == AW'(DEPTH - 1)) begin
                    done_d = 1'b1;
                    ptr_d  = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
                if (!SCRUB_EN) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (SCRUB_GAP > 0) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                if (!SCRUB_EN) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else if (gap_q == GW'(SCRUB_GAP - 1)) begin
                    state_d = StCheck;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A repair dropped by a colliding client write still counts as a correction.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (CLR_CNT) begin
            err_cnt_d = '0;
        end else if (scrub_hit && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rcorr_d  = rcorr_q;
        rvalid_d = RE;
        if (RE) begin
            rdata_d = rd_vote;
            rcorr_d = rd_mis;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gap_q     <= '0;
            done_q    <= 1'b0;
            err_cnt_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rcorr_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            err_cnt_q <= err_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rcorr_q   <= rcorr_d;
        end
    end

    assign RDATA      = rdata_q;
    assign RVALID     = rvalid_q;
    assign RCORR      = rcorr_q;
    assign SCRUB_BUSY = (state_q != StIdle);
    assign SCRUB_DONE = done_q;
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_tmr_scrub_bank.sv
// Self-checking bench for tmr_scrub_bank: bench-side copy model plus a read scoreboard.
module tb_tmr_scrub_bank;

    logic        CLK = 1'b0;
    logic        RN;
    logic        WE, RE, SCRUB_EN, CLR_CNT, FI_EN;
    logic [3:0]  WADDR, RADDR, FI_ADDR;
    logic [7:0]  WDATA, FI_MASK, RDATA;
    logic [1:0]  FI_COPY;
    logic        RVALID, RCORR, SCRUB_BUSY, SCRUB_DONE;
    logic [15:0] ERR_CNT;

    // Second instance with back-to-back scrubbing, used to reach counter saturation.
    logic        s_en, s_fi_en, s_clr;
    logic [3:0]  s_fi_addr;
    logic [7:0]  s_rdata;
    logic        s_rvalid, s_rcorr, s_busy, s_done;
    logic [15:0] s_err;

    always #5 CLK = ~CLK;

    tmr_scrub_bank #(.WIDTH(8), .DEPTH(16), .SCRUB_GAP(2), .RESET_VAL(8'h00)) u_dut (
        .CLK(CLK), .RN(RN), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .RE(RE), .RADDR(RADDR), .RDATA(RDATA), .RVALID(RVALID), .RCORR(RCORR),
        .SCRUB_EN(SCRUB_EN), .SCRUB_BUSY(SCRUB_BUSY), .SCRUB_DONE(SCRUB_DONE),
        .ERR_CNT(ERR_CNT), .CLR_CNT(CLR_CNT), .FI_EN(FI_EN), .FI_COPY(FI_COPY),
        .FI_ADDR(FI_ADDR), .FI_MASK(FI_MASK)
    );

    tmr_scrub_bank #(.WIDTH(8), .DEPTH(16), .SCRUB_GAP(0), .RESET_VAL(8'h00)) u_sat (
        .CLK(CLK), .RN(RN), .WE(1'b0), .WADDR(4'd0), .WDATA(8'h00),
        .RE(1'b0), .RADDR(4'd0), .RDATA(s_rdata), .RVALID(s_rvalid), .RCORR(s_rcorr),
        .SCRUB_EN(s_en), .SCRUB_BUSY(s_busy), .SCRUB_DONE(s_done),
        .ERR_CNT(s_err), .CLR_CNT(s_clr), .FI_EN(s_fi_en), .FI_COPY(2'd1),
        .FI_ADDR(s_fi_addr), .FI_MASK(8'h01)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       corr;
    } rd_exp_t;

    rd_exp_t     sb_q[$];
    logic [7:0]  ma [16];
    logic [7:0]  mb [16];
    logic [7:0]  mc [16];
    int          exp_err;
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic logic [7:0] mvote(input int a);
        return (ma[a] & mb[a]) | (mb[a] & mc[a]) | (ma[a] & mc[a]);
    endfunction

    function automatic logic mmis(input int a);
        return (ma[a] != mb[a]) || (mb[a] != mc[a]);
    endfunction

    function automatic int count_mis();
        int n = 0;
        for (int i = 0; i < 16; i++) if (mmis(i)) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'h00; mb[i] = 8'h00; mc[i] = 8'h00;
        end
        exp_err = 0;
    endtask

    task automatic model_scrub();
        for (int i = 0; i < 16; i++) begin
            logic [7:0] v;
            v = mvote(i);
            ma[i] = v; mb[i] = v; mc[i] = v;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        WE = 1'b1; WADDR = a; WDATA = d;
        tick();
        WE = 1'b0;
        ma[a] = d; mb[a] = d; mc[a] = d;
    endtask

    task automatic do_fi(input logic [1:0] cp, input logic [3:0] a, input logic [7:0] m);
        FI_EN = 1'b1; FI_COPY = cp; FI_ADDR = a; FI_MASK = m;
        tick();
        FI_EN = 1'b0;
        if (cp == 2'd0) ma[a] = ma[a] ^ m;
        if (cp == 2'd1) mb[a] = mb[a] ^ m;
        if (cp == 2'd2) mc[a] = mc[a] ^ m;
    endtask

    task automatic do_read(input logic [3:0] a, input string name);
        rd_exp_t e;
        sb_q.push_back({mvote(a), mmis(a)});
        RE = 1'b1; RADDR = a;
        tick();
        RE = 1'b0;
        e = sb_q.pop_front();
        tests_run++;
        if (RVALID !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s rvalid got %b exp 1", name, RVALID);
        end else if (RDATA !== e.data || RCORR !== e.corr) begin
            tests_failed++;
            $display("FAIL %s data/corr got %h/%b exp %h/%b", name, RDATA, RCORR, e.data, e.corr);
        end
        tick();
        tests_run++;
        if (RVALID !== 1'b0 || RDATA !== e.data) begin
            tests_failed++;
            $display("FAIL %s hold got rvalid %b data %h exp 0 %h", name, RVALID, RDATA, e.data);
        end
    endtask

    task automatic check_err(input string name);
        tests_run++;
        if (ERR_CNT !== 16'(exp_err)) begin
            tests_failed++;
            $display("FAIL %s err_cnt got %0d exp %0d", name, ERR_CNT, exp_err);
        end
    endtask

    task automatic scrub_pass(input string name);
        int done_n = 0;
        int done_at = 0;
        int errs;
        errs = count_mis();
        SCRUB_EN = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            tick();
            if (c == 1) begin
                tests_run++;
                if (SCRUB_BUSY !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL %s busy got %b exp 1", name, SCRUB_BUSY);
                end
            end
            if (SCRUB_DONE === 1'b1) begin
                done_n++;
                done_at = c;
            end
        end
        SCRUB_EN = 1'b0;
        model_scrub();
        exp_err = exp_err + errs;
        tests_run++;
        if (done_n != 1 || done_at != 47) begin
            tests_failed++;
            $display("FAIL %s done pulses %0d at %0d exp 1 at 47", name, done_n, done_at);
        end
        check_err(name);
        tick();
        tick();
        tests_run++;
        if (SCRUB_BUSY !== 1'b0 || SCRUB_DONE !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s idle got busy %b done %b exp 0 0", name, SCRUB_BUSY, SCRUB_DONE);
        end
    endtask

    task automatic test_reset();
        RN = 1'b0;
        #2;
        tests_run++;
        if (RDATA !== 8'h00 || RVALID !== 1'b0 || RCORR !== 1'b0 || SCRUB_BUSY !== 1'b0 ||
            SCRUB_DONE !== 1'b0 || ERR_CNT !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_outputs got %h %b %b %b %b %h exp 00 0 0 0 0 0000",
                     RDATA, RVALID, RCORR, SCRUB_BUSY, SCRUB_DONE, ERR_CNT);
        end
        #20;
        RN = 1'b1;
        tick();
        do_read(4'd5, "reset_read5");
        check_err("reset_err");
        tests_run++;
        if (SCRUB_BUSY !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy got %b exp 0", SCRUB_BUSY);
        end
    endtask

    task automatic test_read_vote();
        do_write(4'd3, 8'hA5);
        do_fi(2'd1, 4'd3, 8'h0F);
        do_read(4'd3, "vote_read3");
        do_read(4'd3, "vote_reread3");
    endtask

    task automatic test_scrub_repair();
        scrub_pass("scrub_pass1");
        do_read(4'd3, "scrub_read3");
    endtask

    task automatic test_double_fault();
        do_write(4'd7, 8'h5A);
        do_fi(2'd0, 4'd7, 8'h01);
        do_fi(2'd2, 4'd7, 8'h80);
        do_read(4'd7, "dbl_pre_read7");
        scrub_pass("scrub_pass2");
        do_read(4'd7, "dbl_read7");
    endtask

    task automatic test_collision();
        int done_n = 0;
        int errs;
        do_fi(2'd0, 4'd9, 8'h10);
        errs = count_mis();
        SCRUB_EN = 1'b1;
        for (int c = 1; c <= 47; c++) begin
            tick();
            if (SCRUB_DONE === 1'b1) done_n++;
            if (c == 28) begin
                WE = 1'b1; WADDR = 4'd9; WDATA = 8'h3C;
                FI_EN = 1'b1; FI_COPY = 2'd2; FI_ADDR = 4'd9; FI_MASK = 8'hFF;
            end else begin
                WE = 1'b0;
                FI_EN = 1'b0;
            end
        end
        SCRUB_EN = 1'b0;
        model_scrub();
        ma[9] = 8'h3C; mb[9] = 8'h3C; mc[9] = 8'h3C;
        exp_err = exp_err + errs;
        tests_run++;
        if (done_n != 1) begin
            tests_failed++;
            $display("FAIL coll_done pulses %0d exp 1", done_n);
        end
        check_err("coll_err");
        tick();
        tick();
        do_read(4'd9, "coll_read9");
    endtask

    task automatic test_saturation();
        s_fi_addr = 4'd0;
        s_fi_en   = 1'b1;
        s_en      = 1'b1;
        for (int k = 0; k <= 65540; k++) begin
            tick();
            s_fi_addr = 4'((k + 1) % 16);
            if (k == 100) begin
                tests_run++;
                if (s_err !== 16'd100) begin
                    tests_failed++;
                    $display("FAIL sat_mid got %0d exp 100", s_err);
                end
            end
        end
        tests_run++;
        if (s_err !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hold got %h exp ffff", s_err);
        end
        s_clr = 1'b1;
        tick();
        tests_run++;
        if (s_err !== 16'h0000) begin
            tests_failed++;
            $display("FAIL sat_clr got %h exp 0000", s_err);
        end
        s_clr = 1'b0; s_fi_en = 1'b0; s_en = 1'b0;
        tick();
        tests_run++;
        if (s_err !== 16'h0001) begin
            tests_failed++;
            $display("FAIL sat_after_clr got %h exp 0001", s_err);
        end
    endtask

    task automatic test_reset_mid_pass();
        int c = 0;
        bit found = 0;
        do_read(4'd9, "rst_pre_read9");
        SCRUB_EN = 1'b1;
        repeat (20) tick();
        #2;
        RN = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (RDATA !== 8'h00 || RVALID !== 1'b0 || SCRUB_BUSY !== 1'b0 ||
            SCRUB_DONE !== 1'b0 || ERR_CNT !== 16'h0000 || s_err !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rst_async got %h %b %b %b %h %h exp 00 0 0 0 0000 0000",
                     RDATA, RVALID, SCRUB_BUSY, SCRUB_DONE, ERR_CNT, s_err);
        end
        tick();
        #2;
        RN = 1'b1;
        for (int i = 1; i <= 60 && !found; i++) begin
            tick();
            if (SCRUB_DONE === 1'b1) begin
                found = 1;
                c = i;
            end
        end
        tests_run++;
        if (!found || c != 47) begin
            tests_failed++;
            $display("FAIL rst_first_done found %0d at %0d exp 1 at 47", found, c);
        end
        found = 0;
        for (int i = 1; i <= 60 && !found; i++) begin
            tick();
            if (SCRUB_DONE === 1'b1) begin
                found = 1;
                c = i;
            end
        end
        tests_run++;
        if (!found || c != 48) begin
            tests_failed++;
            $display("FAIL rst_pass_len found %0d at %0d exp 1 at 48", found, c);
        end
        SCRUB_EN = 1'b0;
        tick();
        tick();
        check_err("rst_err");
        do_read(4'd3, "rst_read3");
    endtask

    initial begin
        WE = 0; RE = 0; SCRUB_EN = 0; CLR_CNT = 0; FI_EN = 0;
        WADDR = '0; RADDR = '0; FI_ADDR = '0; WDATA = '0; FI_MASK = '0; FI_COPY = '0;
        s_en = 0; s_fi_en = 0; s_clr = 0; s_fi_addr = '0;
        model_reset();
        test_reset();
        test_read_vote();
        test_scrub_repair();
        test_double_fault();
        test_collision();
        test_saturation();
        test_reset_mid_pass();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL sb_drain got %0d exp 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
